// File: rtl/encoder_4_2.sv
// encoder_4_2 -- registered 4-to-2 priority encoder (a > b > c > d).
// Optional feature: define ENCODER_4_2_ERR_EN to add the registered
// multi-hot err output.
module encoder_4_2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic x,
  output logic y,
  output logic valid
`ifdef ENCODER_4_2_ERR_EN
  ,
  output logic err
`endif
);

  logic [1:0] code_nxt;
  logic       any_req;

  // Priority resolve: the highest active request sets the code; none -> 00.
  always_comb begin
    code_nxt = 2'b00;
    if (a)      code_nxt = 2'b11;
    else if (b) code_nxt = 2'b10;
    else if (c) code_nxt = 2'b01;
    any_req = a | b | c | d;
  end

  // Output register: reset dominates, en=0 holds the last capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      x     <= 1'b0;
      y     <= 1'b0;
      valid <= 1'b0;
    end else if (en) begin
      x     <= code_nxt[1];
      y     <= code_nxt[0];
      valid <= any_req;
    end
  end

`ifdef ENCODER_4_2_ERR_EN
  logic multi_hot;

  // Two or more requests active: any pair being set is enough.
  always_comb begin
    multi_hot = (a & b) | (a & c) | (a & d) | (b & c) | (b & d) | (c & d);
  end

  // err shares the capture/hold/reset behaviour of the code register.
  always_ff @(posedge clk) begin
    if (rst)     err <= 1'b0;
    else if (en) err <= multi_hot;
  end
`endif

endmodule

// File: tb/tb_encoder_4_2.sv
// tb_encoder_4_2 -- directed test plan plus randomized stimulus, checked
// against a priority-search reference model. Honors ENCODER_4_2_ERR_EN.
module tb_encoder_4_2;

  logic clk = 1'b0;
  logic rst, en, a, b, c, d;
  logic x, y, valid;
`ifdef ENCODER_4_2_ERR_EN
  logic err;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  // reference model state
  logic [1:0] m_code;
  logic       m_valid;
  logic       m_err;

  always #5 clk = ~clk;

  encoder_4_2 dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .x     (x),
    .y     (y),
    .valid (valid)
`ifdef ENCODER_4_2_ERR_EN
    ,
    .err   (err)
`endif
  );

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: requests as an index-ordered vector; the code is the index of
  // the highest set bit, valid is "any set", err is "popcount >= 2".
  task automatic model_edge(input logic r, input logic e, input logic [3:0] req);
    int hi, cnt;
    if (r) begin
      m_code = 2'd0; m_valid = 1'b0; m_err = 1'b0;
    end else if (e) begin
      hi = -1; cnt = 0;
      for (int i = 0; i < 4; i++) begin
        if (req[i]) begin
          hi = i;
          cnt++;
        end
      end
      m_code  = (hi < 0) ? 2'd0 : 2'(hi);
      m_valid = (cnt > 0);
      m_err   = (cnt >= 2);
    end
  endtask

  // Apply one cycle: drive on negedge, update model at posedge, check #1 later.
  task automatic step(input logic r, input logic e, input logic [3:0] abcd, input string tag);
    @(negedge clk);
    rst = r; en = e; {a, b, c, d} = abcd;
    @(posedge clk);
    model_edge(r, e, {a, b, c, d});
    #1;
    // scramble inputs between edges; outputs must not follow
    {a, b, c, d} = ~abcd;
    #1;
    chk({tag, ".xy"}, {2'b00, x, y}, {2'b00, m_code});
    chk({tag, ".valid"}, {3'b000, valid}, {3'b000, m_valid});
`ifdef ENCODER_4_2_ERR_EN
    chk({tag, ".err"}, {3'b000, err}, {3'b000, m_err});
`endif
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; {a, b, c, d} = 4'b0000;
    m_code = 2'd0; m_valid = 1'b0; m_err = 1'b0;

    // reset for 2 cycles with a=1, en=1
    step(1'b1, 1'b1, 4'b1000, "rst0");
    step(1'b1, 1'b1, 4'b1000, "rst1");

    // one-hot sweep d, c, b, a
    step(1'b0, 1'b1, 4'b0001, "hot_d");
    step(1'b0, 1'b1, 4'b0010, "hot_c");
    step(1'b0, 1'b1, 4'b0100, "hot_b");
    step(1'b0, 1'b1, 4'b1000, "hot_a");

    // no request
    step(1'b0, 1'b1, 4'b0000, "none");

    // multi-hot priority
    step(1'b0, 1'b1, 4'b0111, "multi_0111");
    step(1'b0, 1'b1, 4'b1001, "multi_1001");

    // hold: capture c, then en=0 with a=1 for 3 cycles, then en=1
    step(1'b0, 1'b1, 4'b0010, "hold_cap");
    step(1'b0, 1'b0, 4'b1000, "hold0");
    step(1'b0, 1'b0, 4'b1000, "hold1");
    step(1'b0, 1'b0, 4'b1000, "hold2");
    step(1'b0, 1'b1, 4'b1000, "hold_rel");

    // reset mid-stream with 11 registered, then release with d=1
    step(1'b1, 1'b1, 4'b1000, "mid_rst");
    step(1'b0, 1'b1, 4'b0001, "post_rst");

    // reset with en=0 must still clear
    step(1'b0, 1'b1, 4'b1100, "pre_rst_en0");
    step(1'b1, 1'b0, 4'b1111, "rst_en0");

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/encoder_4_2.md
# encoder_4_2

Registered 4-to-2 priority encoder. It converts four request lines (a, b, c, d) into a 2-bit binary code (x, y) and a valid flag, all registered on the system clock. It sits in front of control logic that needs a compact index of the highest-priority active request. Priority is fixed: a is the highest, then b, then c, then d.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  capture enable; when 0, all outputs hold.
- a  input  1  request 3; highest priority.
- b  input  1  request 2.
- c  input  1  request 1.
- d  input  1  request 0; lowest priority.
- x  output  1  code MSB, registered.
- y  output  1  code LSB, registered.
- valid  output  1  registered; 1 when at least one request was active at capture.
- err  output  1  registered; present only with ENCODER_4_2_ERR_EN (see Configuration).

## Operation
- Code mapping {x,y}, with the highest active input taking precedence:
  - a = 1 → 11
  - else b = 1 → 10
  - else c = 1 → 01
  - else d = 1 → 00
- No request active:
  - {x,y} = 00, valid = 0.
  - This distinguishes "d only" from "none" through valid alone.
- Multi-hot input:
  - The highest-priority input wins.
  - valid = 1.
  - err = 1 when the macro is enabled.
- en = 0:
  - x, y, valid and err hold their last registered values.
  - Inputs are ignored.
- Inputs are sampled only at the rising edge of clk. Glitches between edges have no effect.
- Inputs are assumed synchronous to clk. No internal synchronizers.

## Timing
- Latency is 1 clock: inputs present at edge N appear on the outputs after edge N.
- Throughput is one new code per cycle while en = 1.
- Reset:
  - rst = 1 at a rising edge forces x = 0, y = 0, valid = 0, err = 0.
  - Reset overrides en and all request inputs.
- Reset mid-operation: the previous code is discarded at the reset edge. The first post-reset code appears one cycle after rst deasserts, with en = 1.
- Simultaneous rst = 1 and en = 1: reset wins.
- Outputs are pure flop outputs, with no combinational path from inputs to outputs.

## Configuration
- Macro: ENCODER_4_2_ERR_EN.
- Defined:
  - The err output port exists.
  - err registers 1 when two or more of a, b, c, d are 1 at a capture edge, else 0.
  - err resets to 0 and holds when en = 0.
- Undefined:
  - The err port and its logic are absent.
  - Multi-hot inputs resolve by priority silently.
  - All other behaviour is identical.

## Test plan
- Reset: assert rst for 2 cycles with a = 1 and en = 1 → x = 0, y = 0, valid = 0, err = 0 throughout.
- One-hot sweep, en = 1, one pattern per cycle:
  - d → xy = 00
  - c → 01
  - b → 10
  - a → 11
  - Each has valid = 1 and err = 0, and each appears one cycle after its input.
- No request: abcd = 0000 → xy = 00, valid = 0, err = 0.
- Priority and multi-hot: abcd = 0111 → xy = 10, valid = 1, err = 1 (with the macro). abcd = 1001 → xy = 11, valid = 1, err = 1.
- Hold: capture c (xy = 01), then drop en and drive a = 1 for 3 cycles → xy stays 01 and valid stays 1. Raise en → xy = 11 the next cycle.
- Reset mid-stream: with xy = 11 registered, assert rst for 1 cycle → all outputs 0 after that edge. Release rst with d = 1 → xy = 00 and valid = 1 one cycle later.
